// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: builds the per-stage hold vector,
// issues registered redirect flushes and guards multi-cycle EX operations with a watchdog.
module pipe_stall_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        mc_start,
  input  logic        mc_done,
  input  logic        flush_req,
  input  logic [31:0] new_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        mc_cancel_o,
  output logic        mc_timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [1:0]  state_dbg_o
);

  // Handshake: mc_start/mc_done/flush_req are single-cycle pulses sampled on the
  // rising edge; stallreq_id is a level that takes effect in the same cycle.

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MC_WAIT = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;

  localparam logic [5:0] STALL_LOAD_USE = 6'b000111;
  localparam logic [5:0] STALL_MC       = 6'b001111;

  localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(MAX_WAIT - 1);

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] wcnt, wcnt_n;
  logic [31:0]      pc_q, pc_n;

  always_comb begin
    state_n      = state;
    wcnt_n       = wcnt;
    pc_n         = pc_q;
    stall_o      = 6'b0;
    flush_o      = 1'b0;
    mc_cancel_o  = 1'b0;
    mc_timeout_o = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          pc_n    = new_pc_i;
          state_n = FLUSH;
        end else if (mc_start) begin
          stall_o = STALL_MC;
          wcnt_n  = '0;
          state_n = MC_WAIT;
        end else if (stallreq_id) begin
          stall_o = STALL_LOAD_USE;
        end
      end
      MC_WAIT: begin
        if (flush_req) begin
          mc_cancel_o = 1'b1;
          pc_n        = new_pc_i;
          state_n     = FLUSH;
        end else if (mc_done) begin
          // Release the hold so the finished result moves on to MEM.
          state_n = IDLE;
        end else if (wcnt == WCNT_LAST) begin
          mc_cancel_o  = 1'b1;
          mc_timeout_o = 1'b1;
          state_n      = IDLE;
        end else begin
          stall_o = STALL_MC;
          wcnt_n  = wcnt + 1'b1;
        end
      end
      FLUSH: begin
        flush_o = 1'b1;
        if (flush_req) begin
          pc_n = new_pc_i;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
      pc_q  <= 32'h0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      pc_q  <= pc_n;
    end
  end

  // Counts cycles in which the ID stage is held; sticks at the maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= 32'h0;
    end else if (stall_o[2] && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

  assign new_pc_o    = pc_q;
  assign state_dbg_o = state;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_stall_ctrl;

  localparam int MAX_WAIT = 64;
  localparam int CNT_W    = 7;
  localparam int W        = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        mc_start = 1'b0;
  logic        mc_done = 1'b0;
  logic        flush_req = 1'b0;
  logic [31:0] new_pc_i = 32'h0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        mc_cancel_o;
  logic        mc_timeout_o;
  logic [31:0] stall_cnt_o;
  logic [1:0]  state_dbg_o;

  int n_vec = 0;
  int n_err = 0;

  pipe_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .mc_start(mc_start),
    .mc_done(mc_done), .flush_req(flush_req), .new_pc_i(new_pc_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .mc_cancel_o(mc_cancel_o), .mc_timeout_o(mc_timeout_o),
    .stall_cnt_o(stall_cnt_o), .state_dbg_o(state_dbg_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // busy/age: a multi-cycle op is outstanding, age = cycles since it started.
  // flushing: this cycle is a flush cycle. exp_q holds accepted redirect targets.
  bit             m_busy = 0;
  int             m_age = 0;
  bit             m_flushing = 0;
  logic [31:0]    m_tgt = 32'h0;
  longint         m_cnt = 0;
  logic [W-1:0]   exp_q[$];

  always @(negedge clk) begin
    logic [5:0]  e_stall;
    logic        e_flush, e_cancel, e_tout;
    logic [31:0] e_pc;
    logic [1:0]  e_state;
    e_stall = 6'b0; e_flush = 0; e_cancel = 0; e_tout = 0; e_pc = 32'h0;
    if (rst) begin
      m_busy = 0; m_age = 0; m_flushing = 0; m_tgt = 32'h0; m_cnt = 0;
      exp_q.delete();
      e_state = 2'd0;
    end else begin
      e_state = m_flushing ? 2'd2 : (m_busy ? 2'd1 : 2'd0);
      if (m_flushing) begin
        e_flush = 1;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL flush_unexpected: flush cycle with no queued target");
        end else begin
          e_pc = exp_q.pop_front();
          chk("flush_target", new_pc_o, e_pc);
        end
      end
      chk("new_pc_held", new_pc_o, m_tgt);
    end
    chk("stall_o", {26'b0, stall_o}, {26'b0, e_stall_calc()});
    chk("flush_o", {31'b0, flush_o}, {31'b0, e_flush});
    chk("mc_cancel_o", {31'b0, mc_cancel_o}, {31'b0, exp_cancel()});
    chk("mc_timeout_o", {31'b0, mc_timeout_o}, {31'b0, exp_timeout()});
    chk("stall_cnt_o", stall_cnt_o, m_cnt[31:0]);
    chk("state_dbg_o", {30'b0, state_dbg_o}, {30'b0, e_state});
    // advance model to what the next rising edge produces
    if (!rst) begin
      e_stall = e_stall_calc();
      if (e_stall[2] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_flushing) begin
        if (flush_req) begin m_tgt = new_pc_i; exp_q.push_back(new_pc_i); end
        else m_flushing = 0;
      end else if (flush_req) begin
        m_busy = 0; m_flushing = 1; m_tgt = new_pc_i; exp_q.push_back(new_pc_i);
      end else if (m_busy) begin
        if (mc_done || m_age == MAX_WAIT) m_busy = 0;
        else m_age++;
      end else if (mc_start) begin
        m_busy = 1; m_age = 1;
      end
    end
  end

  function automatic logic [5:0] e_stall_calc();
    if (rst || m_flushing || flush_req) return 6'b0;
    if (m_busy) return (mc_done || m_age == MAX_WAIT) ? 6'b0 : 6'b001111;
    if (mc_start) return 6'b001111;
    if (stallreq_id) return 6'b000111;
    return 6'b0;
  endfunction

  function automatic logic exp_cancel();
    if (rst || m_flushing || !m_busy) return 1'b0;
    return flush_req || (!mc_done && m_age == MAX_WAIT);
  endfunction

  function automatic logic exp_timeout();
    if (rst || m_flushing || !m_busy || flush_req || mc_done) return 1'b0;
    return m_age == MAX_WAIT;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    stallreq_id = 0; mc_start = 0; mc_done = 0; flush_req = 0; new_pc_i = 32'h0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int first_to;
    logic [31:0] cnt_base;
    step(3);
    chk("reset_stall", {26'b0, stall_o}, 32'h0);
    chk("reset_cnt", stall_cnt_o, 32'h0);
    rst = 0;
    step(2);

    // load-use for exactly 3 cycles
    cnt_base = stall_cnt_o;
    stallreq_id = 1;
    #1 chk("lu_same_cycle", {26'b0, stall_o}, 32'h07);
    step(3);
    stallreq_id = 0;
    #1 chk("lu_release", {26'b0, stall_o}, 32'h0);
    chk("lu_count", stall_cnt_o, 32'd3);
    step(2);

    // multi-cycle: stall 5 cycles, done on the 6th; ID requests ignored meanwhile
    mc_start = 1;
    #1 chk("mc_start_stall", {26'b0, stall_o}, 32'h0F);
    step(1);
    mc_start = 0; stallreq_id = 1;
    step(4);
    stallreq_id = 0; mc_done = 1;
    #1 chk("mc_done_release", {26'b0, stall_o}, 32'h0);
    step(1);
    mc_done = 0;
    #1 chk("mc_back_idle", {30'b0, state_dbg_o}, 32'd0);
    chk("mc_count", stall_cnt_o, 32'd8);

    // mc_done in IDLE ignored; mc_start with simultaneous mc_done still waits
    mc_done = 1; step(1);
    mc_start = 1; step(1);
    mc_start = 0; mc_done = 0;
    #1 chk("start_ignores_done", {30'b0, state_dbg_o}, 32'd1);
    mc_done = 1; step(1); mc_done = 0;
    step(1);

    // watchdog expiry
    mc_start = 1; step(1); mc_start = 0;
    first_to = -1;
    for (int i = 1; i <= MAX_WAIT + 6; i++) begin
      #1;
      if (mc_timeout_o && first_to < 0) begin
        first_to = i;
        chk("wd_cancel", {31'b0, mc_cancel_o}, 32'd1);
        chk("wd_stall", {26'b0, stall_o}, 32'h0);
      end
      step(1);
    end
    chk("wd_expiry_cycle", first_to, MAX_WAIT);

    // flush during MC_WAIT at cycle 3 of the wait
    mc_start = 1; step(1); mc_start = 0;
    step(2);
    flush_req = 1; new_pc_i = 32'h0000_0040;
    #1 chk("fl_mc_cancel", {31'b0, mc_cancel_o}, 32'd1);
    step(1);
    idle_inputs();
    #1 chk("fl_mc_flush", {31'b0, flush_o}, 32'd1);
    chk("fl_mc_pc", new_pc_o, 32'h40);
    step(1);
    chk("fl_mc_idle", {30'b0, state_dbg_o}, 32'd0);
    step(1);

    // back-to-back flush, stall requests ignored
    flush_req = 1; new_pc_i = 32'h100; stallreq_id = 1;
    #1 chk("bb_flush_wins", {26'b0, stall_o}, 32'h0);
    step(1);
    new_pc_i = 32'h200; mc_start = 1; mc_done = 1;
    #1 chk("bb_first_flush", {31'b0, flush_o}, 32'd1);
    chk("bb_first_pc", new_pc_o, 32'h100);
    chk("bb_stall_ignored", {26'b0, stall_o}, 32'h0);
    step(1);
    idle_inputs();
    #1 chk("bb_second_flush", {31'b0, flush_o}, 32'd1);
    chk("bb_second_pc", new_pc_o, 32'h200);
    step(1);
    chk("bb_done", {31'b0, flush_o}, 32'd0);
    step(1);

    // asynchronous reset mid-MC_WAIT
    mc_start = 1; step(1); mc_start = 0;
    step(3);
    #2 rst = 1;
    #1;
    chk("ar_stall", {26'b0, stall_o}, 32'h0);
    chk("ar_cancel", {31'b0, mc_cancel_o}, 32'd0);
    chk("ar_cnt", stall_cnt_o, 32'h0);
    chk("ar_pc", new_pc_o, 32'h0);
    chk("ar_state", {30'b0, state_dbg_o}, 32'd0);
    step(2);
    rst = 0;
    step(4);
    chk("ar_quiet", {26'b0, stall_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
